// File: rtl/pea_pkg.sv
// Shared constants for the PEA firing-rule logic: actor modes, opcodes,
// command-word field positions and the count-width helper.
package pea_pkg;

    localparam logic [1:0] MODE_GET_CMD = 2'd0;
    localparam logic [1:0] MODE_EXEC    = 2'd1;
    localparam logic [1:0] MODE_STATUS  = 2'd2;

    localparam logic [2:0] OP_STP = 3'd0;
    localparam logic [2:0] OP_EVP = 3'd1;
    localparam logic [2:0] OP_EVB = 3'd2;
    localparam logic [2:0] OP_CLR = 3'd3;

    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 2;
    localparam int SLOT_LSB = 3;
    localparam int SLOT_MSB = 5;
    localparam int ARG_LSB  = 6;

    // Count width for a FIFO of depth n: 1 for n <= 1, otherwise ceil(log2(n)).
    function automatic int log2(input int n);
        int r;
        int v;
        if (n <= 1) return 1;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pea_enable_if.sv
// Bundle between the PEA actor (master) and its firing-rule block (slave).
// enable is advisory only: the actor samples it and decides whether to fire.
interface pea_enable_if #(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024
);
    import pea_pkg::*;

    localparam int cw = log2(buffer_size);

    logic [cw-1:0]        control_pop;
    logic [cw-1:0]        data_pop;
    logic [cw-1:0]        result_free_space;
    logic [cw-1:0]        status_free_space;
    logic [1:0]           mode;
    logic [word_size-1:0] control_in;
    logic                 enable;

    modport master (
        output control_pop, data_pop, result_free_space, status_free_space,
        output mode, control_in,
        input  enable
    );

    modport slave (
        input  control_pop, data_pop, result_free_space, status_free_space,
        input  mode, control_in,
        output enable
    );

endinterface

// File: rtl/pea_cmd_req.sv
// Decodes the pending command word into the token/space counts it needs to fire.
// Define PEA_DEGREE_CHECK_EN to treat STP with arg > max_degree as invalid.
module pea_cmd_req
    import pea_pkg::*;
#(
    parameter int word_size  = 16,
    parameter int max_degree = 10,
    localparam int aw        = word_size - ARG_LSB,
    localparam int nw        = aw + 1
) (
    input  logic [word_size-1:0] control_in,
    output logic [nw-1:0]        need_data,
    output logic [nw-1:0]        need_result,
    output logic [nw-1:0]        need_status,
    output logic                 valid
);

    logic [2:0]    op;
    logic [aw-1:0] arg;
    logic [2:0]    unused_slot;
    logic          over_degree;

    assign op          = control_in[OP_MSB:OP_LSB];
    assign arg         = control_in[word_size-1:ARG_LSB];
    assign unused_slot = control_in[SLOT_MSB:SLOT_LSB];
    assign over_degree = ({1'b0, arg} > nw'(max_degree));

`ifndef PEA_DEGREE_CHECK_EN
    logic unused_over_degree;
    assign unused_over_degree = over_degree;
`endif

    // Every command, including invalid ones, reports one status word.
    always_comb begin
        need_data   = '0;
        need_result = '0;
        need_status = nw'(1);
        valid       = 1'b1;
        case (op)
            OP_STP: begin
`ifdef PEA_DEGREE_CHECK_EN
                if (!over_degree) need_data = {1'b0, arg} + nw'(1);
`else
                need_data = {1'b0, arg} + nw'(1);
`endif
            end
            OP_EVP: begin
                need_data   = nw'(1);
                need_result = nw'(1);
            end
            OP_EVB: begin
                need_data   = {1'b0, arg};
                need_result = {1'b0, arg};
                valid       = (arg != '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pea_enable.sv
// Firing-rule logic for the PEA actor: registers whether the current mode has
// enough input tokens and output space. Honours PEA_DEGREE_CHECK_EN via pea_cmd_req.
module pea_enable
    import pea_pkg::*;
#(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024,
    parameter int max_degree  = 10
) (
    input  logic         clk,
    input  logic         rst,
    pea_enable_if.slave  bus
);

    localparam int cw    = log2(buffer_size);
    localparam int nw    = word_size - ARG_LSB + 1;
    localparam int cmp_w = (cw > nw) ? cw : nw;

    logic [nw-1:0] need_data;
    logic [nw-1:0] need_result;
    logic [nw-1:0] need_status;
    logic          cmd_valid;
    logic          exec_ok;
    logic          fire;

    pea_cmd_req #(
        .word_size  (word_size),
        .max_degree (max_degree)
    ) u_cmd_req (
        .control_in  (bus.control_in),
        .need_data   (need_data),
        .need_result (need_result),
        .need_status (need_status),
        .valid       (cmd_valid)
    );

    // Both sides are zero-extended to a common width so the compare is unsigned.
    assign exec_ok = cmd_valid
                   && (cmp_w'(bus.data_pop)          >= cmp_w'(need_data))
                   && (cmp_w'(bus.result_free_space) >= cmp_w'(need_result))
                   && (cmp_w'(bus.status_free_space) >= cmp_w'(need_status));

    always_comb begin
        fire = 1'b0;
        case (bus.mode)
            MODE_GET_CMD: fire = (bus.control_pop != '0);
            MODE_EXEC:    fire = exec_ok;
            MODE_STATUS:  fire = (bus.status_free_space != '0);
            default:      fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bus.enable <= 1'b0;
        else      bus.enable <= fire;
    end

endmodule

// File: tb/tb_pea_enable.sv
// Directed bench for pea_enable: vector table plus reset and latency sequences.
module tb_pea_enable;
    import pea_pkg::*;

    localparam int CW = 10;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] ctl;
        logic [CW-1:0] cp;
        logic [CW-1:0] dp;
        logic [CW-1:0] rfs;
        logic [CW-1:0] sfs;
        logic        exp;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    vec_t vecs[$];

    pea_enable_if #(.word_size(16), .buffer_size(1024)) bus ();

    pea_enable #(
        .word_size   (16),
        .buffer_size (1024),
        .max_degree  (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] cmd(input int op, input int arg);
        logic [15:0] w;
        w = 16'(arg) << 6;
        w = w | 16'(op);
        return w;
    endfunction

    function automatic vec_t mk(input logic [1:0] m, input logic [15:0] c,
                                input int cp, input int dp, input int rfs,
                                input int sfs, input logic e);
        vec_t v;
        v.mode = m;
        v.ctl  = c;
        v.cp   = CW'(cp);
        v.dp   = CW'(dp);
        v.rfs  = CW'(rfs);
        v.sfs  = CW'(sfs);
        v.exp  = e;
        return v;
    endfunction

    task automatic check(input string name, input logic got, input logic exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: enable=%b expected %b", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.mode              = v.mode;
        bus.control_in        = v.ctl;
        bus.control_pop       = v.cp;
        bus.data_pop          = v.dp;
        bus.result_free_space = v.rfs;
        bus.status_free_space = v.sfs;
    endtask

    logic deg_exp;

    initial begin
        tests = 0;
        fails = 0;
`ifdef PEA_DEGREE_CHECK_EN
        deg_exp = 1'b1;
`else
        deg_exp = 1'b0;
`endif
        // mode, control_in, control_pop, data_pop, result_free, status_free, expected
        vecs.push_back(mk(2'b00, 16'h0000,    0,    0,    0,    0, 1'b0));
        vecs.push_back(mk(2'b00, 16'h0000,    1,    0,    0,    0, 1'b1));
        vecs.push_back(mk(2'b00, 16'hffff, 1023,    0,    0,    0, 1'b1));
        vecs.push_back(mk(2'b01, cmd(0, 4),   0,    4,    0,    1, 1'b0));
        vecs.push_back(mk(2'b01, cmd(0, 4),   0,    5,    0,    1, 1'b1));
        vecs.push_back(mk(2'b01, cmd(0, 4),   0,    5,    0,    0, 1'b0));
        vecs.push_back(mk(2'b01, cmd(0, 4) | 16'h0038, 0, 1023, 0, 1, 1'b1));
        vecs.push_back(mk(2'b01, cmd(0, 10),  0,   10,    0,    1, 1'b0));
        vecs.push_back(mk(2'b01, cmd(0, 10),  0,   11,    0,    1, 1'b1));
        vecs.push_back(mk(2'b01, cmd(1, 0),   0,    1,    1,    1, 1'b1));
        vecs.push_back(mk(2'b01, cmd(1, 0),   0,    0,    1,    1, 1'b0));
        vecs.push_back(mk(2'b01, cmd(1, 0),   0,    1,    0,    1, 1'b0));
        vecs.push_back(mk(2'b01, cmd(1, 0),   0,    1,    1,    0, 1'b0));
        vecs.push_back(mk(2'b01, cmd(2, 8),   0,    8,    7,    1, 1'b0));
        vecs.push_back(mk(2'b01, cmd(2, 8),   0,    8,    8,    1, 1'b1));
        vecs.push_back(mk(2'b01, cmd(2, 0),   0,    8,    8,    1, 1'b0));
        vecs.push_back(mk(2'b01, cmd(2, 8),   0,    7,    8,    1, 1'b0));
        vecs.push_back(mk(2'b01, cmd(2, 1023), 0, 1023, 1023,   1, 1'b1));
        vecs.push_back(mk(2'b01, cmd(3, 0),   0,    0,    0,    1, 1'b1));
        vecs.push_back(mk(2'b01, cmd(3, 0),   0,    0,    0,    0, 1'b0));
        vecs.push_back(mk(2'b01, cmd(6, 0),   0,    0,    0,    1, 1'b1));
        vecs.push_back(mk(2'b01, cmd(7, 5),   0, 1023, 1023,    0, 1'b0));
        vecs.push_back(mk(2'b10, 16'h0000,    5,    5,    5,    0, 1'b0));
        vecs.push_back(mk(2'b10, 16'h0000,    0,    0,    0,    1, 1'b1));
        vecs.push_back(mk(2'b11, cmd(1, 0), 1023, 1023, 1023, 1023, 1'b0));
        vecs.push_back(mk(2'b01, cmd(0, 12),  0,    0,    0,    1, deg_exp));
        vecs.push_back(mk(2'b01, cmd(0, 1023), 0, 1023,   0,    1, deg_exp));

        // Reset held with a firing GET_CMD input: enable stays low across edges.
        rst = 1'b1;
        drive(mk(2'b00, 16'h0000, 5, 0, 0, 0, 1'b0));
        #1 rst = 1'b0;
        #1 check("reset_async", bus.enable, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_held", bus.enable, 1'b0);
        rst = 1'b1;
        #1 check("reset_release_pre_edge", bus.enable, 1'b0);
        @(posedge clk);
        #1 check("reset_release_first_edge", bus.enable, 1'b1);

        // One-cycle latency: output holds until the next rising edge.
        @(negedge clk);
        bus.control_pop = '0;
        #1 check("latency_hold", bus.enable, 1'b1);
        @(posedge clk);
        #1 check("latency_update", bus.enable, 1'b0);

        // Mid-operation reset drops enable without waiting for a clock.
        @(negedge clk);
        bus.control_pop = CW'(1);
        @(posedge clk);
        #1 check("mid_pre", bus.enable, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("mid_reset_async", bus.enable, 1'b0);
        @(posedge clk);
        #1 check("mid_reset_held", bus.enable, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check("mid_reset_release", bus.enable, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), bus.enable, vecs[i].exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pea_enable.md
Name: pea_enable

Overview:
- Firing-rule (enable) logic for the Polynomial Evaluation Accelerator (PEA) dataflow actor.
- Watches the token counts of the control and data FIFOs, and the free space of the result and status FIFOs.
- Uses the actor's current mode and the pending command word.
- Asserts a registered `enable` when the actor has enough input tokens and output space to fire in that mode.

Parameters:
- word_size, 16, width of FIFO tokens and of control_in.
- buffer_size, 1024, FIFO depth; count width CW = log2(buffer_size), where log2(1)=1, else ceil(log2).
- max_degree, 10, largest polynomial degree accepted by STP.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- control_pop  input  CW  tokens available in control FIFO.
- data_pop  input  CW  tokens available in data FIFO.
- result_free_space  input  CW  free slots in result FIFO.
- status_free_space  input  CW  free slots in status FIFO.
- mode  input  2  actor mode: 00 GET_CMD, 01 EXEC, 10 STATUS, 11 reserved.
- control_in  input  word_size  current command word (head of control FIFO, already latched by actor).
- enable  output  1  actor may fire this cycle.

Behaviour:
- Reset: rst low forces enable=0 immediately (asynchronous). enable stays 0 until the first rising clk edge after rst returns high. Asserting reset mid-operation has the same effect.
- Latency: fire condition F is combinational from all inputs. enable <= F on every rising clk edge. One-cycle latency, no internal state besides that register.
- Command fields:
  - op = control_in[2:0]
  - slot = control_in[5:3] (ignored here)
  - arg = control_in[word_size-1:6], unsigned
- Opcodes: 0 STP, 1 EVP, 2 EVB, 3 CLR; 4..7 invalid.
- F by mode:
  - GET_CMD: control_pop >= 1.
  - EXEC, by opcode:
    - STP (store arg+1 coefficients): data_pop >= arg+1 AND status_free_space >= 1.
    - EVP (evaluate one x): data_pop >= 1 AND result_free_space >= 1 AND status_free_space >= 1.
    - EVB (evaluate arg x values): arg >= 1 AND data_pop >= arg AND result_free_space >= arg AND status_free_space >= 1.
    - CLR: status_free_space >= 1.
    - Invalid opcode: status_free_space >= 1, so an error status can be emitted.
  - STATUS: status_free_space >= 1.
  - Mode 11: F=0.
- Arithmetic: comparisons are unsigned. arg+1 is computed one bit wider than arg, so arg all-ones does not wrap. A count narrower than arg is zero-extended before comparing.
- Boundaries:
  - Counts of 0 never satisfy a >=1 rule.
  - data_pop exactly equal to the requirement fires.
  - EVB with arg=0 never fires.
  - No pop/push side effects: enable is advisory. The actor clears mode or pops, and enable follows one cycle later.

Optional Feature:
- Macro PEA_DEGREE_CHECK_EN.
- Defined: STP with arg > max_degree is treated as an invalid opcode; requirement is status_free_space >= 1 only, data_pop is ignored.
- Undefined: STP always uses the data_pop >= arg+1 rule, whatever its degree.

Decomposition:
- Package pea_pkg holds:
  - mode localparams (MODE_GET_CMD=2'd0, MODE_EXEC=2'd1, MODE_STATUS=2'd2);
  - opcode localparams (OP_STP=3'd0, OP_EVP=3'd1, OP_EVB=3'd2, OP_CLR=3'd3);
  - field bit positions;
  - the log2 function.
- One natural sub-module: pea_cmd_req. It decodes control_in into required data, result and status counts plus a valid flag. pea_enable compares those counts against the FIFO counts and registers the result.

Test Plan:
- Reset: hold rst=0 with control_pop=5, mode=00 -> enable=0. Release rst -> enable=1 after the first rising clk edge.
- GET_CMD: mode=00. control_pop=0 -> enable=0. control_pop=1 -> enable=1 one cycle later.
- STP: mode=01, op=0, arg=4.
  - data_pop=4, status_free_space=1 -> enable=0.
  - data_pop=5 -> enable=1.
  - Then status_free_space=0 -> enable=0.
- EVB: mode=01, op=2, arg=8.
  - data_pop=8, result_free_space=7 -> enable=0.
  - result_free_space=8, status_free_space=1 -> enable=1.
  - arg=0 -> enable=0.
- Invalid opcode and modes:
  - op=6, status_free_space=1, data_pop=0 -> enable=1.
  - mode=10 with status_free_space=0 -> enable=0.
  - mode=11 with all counts at max -> enable=0.
- PEA_DEGREE_CHECK_EN defined: STP arg=12, data_pop=0, status_free_space=1 -> enable=1. Undefined: same stimulus -> enable=0.
